// File: rtl/muldiv_unit_if.sv
// Handshake bundle between the EX stage and the iterative RV32M multiply/divide unit.
// Signal prefixes are from the unit's side: i_* flow into the unit, o_* flow back to EX.
interface muldiv_unit_if #(
   parameter int XLEN = 32,
   parameter int RD_W = 5
);
   logic            i_flush;
   logic            i_valid_in;
   logic [2:0]      i_funct3;
   logic [XLEN-1:0] i_a;
   logic [XLEN-1:0] i_b;
   logic [RD_W-1:0] i_rd_in;
   logic            o_busy;
   logic            o_stall_req;
   logic            o_valid_out;
   logic [XLEN-1:0] o_result;
   logic [RD_W-1:0] o_rd_out;

   modport master (
      output i_flush, i_valid_in, i_funct3, i_a, i_b, i_rd_in,
      input  o_busy, o_stall_req, o_valid_out, o_result, o_rd_out
   );

   modport slave (
      input  i_flush, i_valid_in, i_funct3, i_a, i_b, i_rd_in,
      output o_busy, o_stall_req, o_valid_out, o_result, o_rd_out
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (shift-add multiply, restoring divide, UNROLL bits/cycle).
// Define MULDIV_FAST_MUL_EN to compute multiplies combinationally at accept (IDLE->FIX->DONE).
module muldiv_unit #(
   parameter int XLEN   = 32,
   parameter int UNROLL = 1,
   parameter int RD_W   = 5
) (
   input  logic         i_clk,
   input  logic         i_reset,
   muldiv_unit_if.slave io_bus
);
   localparam int STEPS = XLEN / UNROLL;
   localparam int CNT_W = $clog2(STEPS + 1);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [2:0]        r_f3;
   logic [RD_W-1:0]   r_rd;
   logic              r_neg_q;
   logic              r_neg_r;
   logic [XLEN-1:0]   r_opnd;
   logic [2*XLEN-1:0] r_acc;
   logic [XLEN-1:0]   r_result;
   logic [RD_W-1:0]   r_rd_out;

   logic              w_busy;
   logic              w_stall;
   logic              w_valid;
   logic              w_accept;
   logic              w_is_div;
   logic              w_a_sgn;
   logic              w_b_sgn;
   logic              w_a_neg;
   logic              w_b_neg;
   logic [XLEN-1:0]   w_a_mag;
   logic [XLEN-1:0]   w_b_mag;
   logic              w_div_zero;
   logic              w_div_ovf;
   logic              w_fast_div;
   logic [XLEN-1:0]   w_fast_res;

   logic [2*XLEN-1:0] w_acc_step;
   logic [XLEN:0]     w_rem_sh;
   logic [XLEN-1:0]   w_quo_sh;
   logic [XLEN:0]     w_sum;

   logic [2*XLEN-1:0] w_prod_fix;
   logic [XLEN-1:0]   w_quo_fix;
   logic [XLEN-1:0]   w_rem_fix;
   logic [XLEN-1:0]   w_fix_res;

   // Operand decode: DIV/REM/MULH sign both operands, MULHSU only rs1.
   assign w_is_div = io_bus.i_funct3[2];
   assign w_a_sgn  = (io_bus.i_funct3 == 3'd1) || (io_bus.i_funct3 == 3'd2) ||
                     (io_bus.i_funct3 == 3'd4) || (io_bus.i_funct3 == 3'd6);
   assign w_b_sgn  = (io_bus.i_funct3 == 3'd1) || (io_bus.i_funct3 == 3'd4) ||
                     (io_bus.i_funct3 == 3'd6);
   assign w_a_neg  = w_a_sgn && io_bus.i_a[XLEN-1];
   assign w_b_neg  = w_b_sgn && io_bus.i_b[XLEN-1];
   assign w_a_mag  = w_a_neg ? (~io_bus.i_a + 1'b1) : io_bus.i_a;
   assign w_b_mag  = w_b_neg ? (~io_bus.i_b + 1'b1) : io_bus.i_b;

   assign w_accept   = (r_state == S_IDLE) && io_bus.i_valid_in && !io_bus.i_flush;
   assign w_div_zero = w_is_div && (io_bus.i_b == '0);
   assign w_div_ovf  = w_is_div && !io_bus.i_funct3[0] &&
                       (io_bus.i_a == {1'b1, {(XLEN-1){1'b0}}}) && (io_bus.i_b == '1);
   assign w_fast_div = w_div_zero || w_div_ovf;

   always_comb begin
      w_fast_res = '0;
      if (w_div_zero) begin
         w_fast_res = io_bus.i_funct3[1] ? io_bus.i_a : '1;
      end else if (w_div_ovf) begin
         w_fast_res = io_bus.i_funct3[1] ? '0 : io_bus.i_a;
      end
   end

`ifdef MULDIV_FAST_MUL_EN
   logic signed [2*XLEN-1:0] w_a_ext;
   logic signed [2*XLEN-1:0] w_b_ext;
   logic signed [2*XLEN-1:0] w_prod_full;

   // Sign-extending both operands to 2*XLEN gives the (XLEN+1)x(XLEN+1) product modulo 2^(2*XLEN).
   assign w_a_ext     = {{XLEN{w_a_sgn && io_bus.i_a[XLEN-1]}}, io_bus.i_a};
   assign w_b_ext     = {{XLEN{w_b_sgn && io_bus.i_b[XLEN-1]}}, io_bus.i_b};
   assign w_prod_full = w_a_ext * w_b_ext;
`endif

   // One CALC cycle: UNROLL restoring-divide or shift-add-multiply steps on r_acc.
   always_comb begin
      w_acc_step = r_acc;
      w_rem_sh   = '0;
      w_quo_sh   = '0;
      w_sum      = '0;
      for (int i = 0; i < UNROLL; i++) begin
         if (r_f3[2]) begin
            w_rem_sh = {w_acc_step[2*XLEN-1:XLEN], w_acc_step[XLEN-1]};
            w_quo_sh = {w_acc_step[XLEN-2:0], 1'b0};
            if (w_rem_sh >= {1'b0, r_opnd}) begin
               w_rem_sh    = w_rem_sh - {1'b0, r_opnd};
               w_quo_sh[0] = 1'b1;
            end
            w_acc_step = {w_rem_sh[XLEN-1:0], w_quo_sh};
         end else begin
            w_sum      = {1'b0, w_acc_step[2*XLEN-1:XLEN]} +
                         (w_acc_step[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
            w_acc_step = {w_sum, w_acc_step[XLEN-1:1]};
         end
      end
   end

   // FIX: restore signs; the remainder follows the dividend.
   assign w_prod_fix = r_neg_q ? (~r_acc + 1'b1) : r_acc;
   assign w_quo_fix  = r_neg_q ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
   assign w_rem_fix  = r_neg_r ? (~r_acc[2*XLEN-1:XLEN] + 1'b1) : r_acc[2*XLEN-1:XLEN];

   always_comb begin
      w_fix_res = '0;
      if (r_f3[2]) begin
         w_fix_res = r_f3[1] ? w_rem_fix : w_quo_fix;
      end else if (r_f3[1:0] == 2'd0) begin
         w_fix_res = w_prod_fix[XLEN-1:0];
      end else begin
         w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_busy      = (r_state == S_CALC) || (r_state == S_FIX);
      w_valid     = (r_state == S_DONE);
      w_stall     = io_bus.i_valid_in && (r_state != S_DONE);
      if (io_bus.i_flush) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (io_bus.i_valid_in) begin
                  if (w_fast_div) begin
                     w_state_nxt = S_DONE;
`ifdef MULDIV_FAST_MUL_EN
                  end else if (!w_is_div) begin
                     w_state_nxt = S_FIX;
`endif
                  end else begin
                     w_state_nxt = S_CALC;
                  end
               end
            end
            S_CALC:  if (r_cnt <= CNT_W'(1)) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_cnt    <= '0;
         r_f3     <= '0;
         r_rd     <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_opnd   <= '0;
         r_acc    <= '0;
         r_result <= '0;
         r_rd_out <= '0;
      end else if (w_accept) begin
         r_f3    <= io_bus.i_funct3;
         r_rd    <= io_bus.i_rd_in;
         r_neg_q <= w_a_neg ^ w_b_neg;
         r_neg_r <= w_a_neg;
         r_cnt   <= CNT_W'(STEPS);
         if (w_is_div) begin
            r_opnd <= w_b_mag;
            r_acc  <= {{XLEN{1'b0}}, w_a_mag};
         end else begin
            r_opnd <= w_a_mag;
`ifdef MULDIV_FAST_MUL_EN
            r_acc   <= w_prod_full;
            r_neg_q <= 1'b0;
`else
            r_acc  <= {{XLEN{1'b0}}, w_b_mag};
`endif
         end
         if (w_fast_div) begin
            r_result <= w_fast_res;
            r_rd_out <= io_bus.i_rd_in;
         end
      end else if (!io_bus.i_flush) begin
         if (r_state == S_CALC) begin
            r_acc <= w_acc_step;
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
         end else if (r_state == S_FIX) begin
            r_result <= w_fix_res;
            r_rd_out <= r_rd;
         end
      end
   end

   assign io_bus.o_busy      = w_busy;
   assign io_bus.o_stall_req = w_stall;
   assign io_bus.o_valid_out = w_valid;
   assign io_bus.o_result    = r_result;
   assign io_bus.o_rd_out    = r_rd_out;
endmodule
